usb3_descramble: RTL and testbench

- RX-side counterpart of the TX scramble/SKP-insertion stage.
- Takes 32-bit PIPE-side symbol words from the RX elastic buffer, strips SKP (K28.1, 8'h3C with K=1) ordered-set symbols, and repacks the surviving symbols into dense 32-bit words.
- Descrambles data symbols with the USB 3.0 LFSR, which is reset on every COM (K28.5, 8'hBC with K=1).
- Output feeds the link-layer RX framing logic.

---
 rtl/usb3_descramble_pkg.sv | 36 +++
 rtl/usb3_rx_pack.sv | 64 ++++++
 rtl/usb3_descramble.sv | 163 ++++++++++++++++
 tb/tb_usb3_descramble.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb3_descramble_pkg.sv
// Shared USB 3.0 symbol constants and the byte-wide scrambler LFSR step.
// The same step function is used on the TX side so loopback is the identity.
package usb3_descramble_pkg;

  localparam logic [7:0]  K_COM             = 8'hBC;
  localparam logic [7:0]  K_SKP             = 8'h3C;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h7DBD;
  // x^16 + x^5 + x^4 + x^3 + 1, Galois form, MSB is the output bit
  localparam logic [15:0] LFSR_TAPS         = 16'h0039;
  localparam int          ACC_SYMS          = 7;

  typedef enum logic [1:0] {
    SYM_DATA,
    SYM_COM,
    SYM_SKP,
    SYM_KOTHER
  } sym_kind_t;

  typedef struct packed {
    logic [15:0] state;
    logic [7:0]  ks;
  } lfsr_step_t;

  // Eight serial steps; keystream bit 0 is produced first.
  function automatic lfsr_step_t lfsr_step8(input logic [15:0] state_in);
    lfsr_step_t r;
    r.state = state_in;
    r.ks    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r.ks[i] = r.state[15];
      r.state = {r.state[14:0], 1'b0} ^ (r.state[15] ? LFSR_TAPS : 16'h0000);
    end
    return r;
  endfunction

endpackage

// File: rtl/usb3_rx_pack.sv
// Seven-symbol accumulator that repacks 0..4 surviving symbols per cycle
// into dense 4-symbol words; flush discards leftovers (bypass mode).
module usb3_rx_pack
  import usb3_descramble_pkg::*;
(
  input  logic        local_clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] symbols,
  input  logic [3:0]  k,
  input  logic [2:0]  count,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_valid
);

  localparam int ACC_W = 8 * ACC_SYMS;

  logic [ACC_W-1:0]    acc_data_reg;
  logic [ACC_SYMS-1:0] acc_k_reg;
  logic [2:0]          acc_cnt_reg;

  logic [ACC_W-1:0]    comb_data;
  logic [ACC_SYMS-1:0] comb_k;
  logic [2:0]          cnt_eff;
  logic [3:0]          total;
  logic [3:0]          total_m4;

  // New symbols are left-aligned and slid in right behind the leftovers;
  // unused lanes upstream are zero so a plain OR merges them.
  always_comb begin
    cnt_eff   = flush ? 3'd0 : acc_cnt_reg;
    comb_data = (flush ? {ACC_W{1'b0}} : acc_data_reg)
              | ({symbols, 24'h000000} >> {cnt_eff, 3'b000});
    comb_k    = (flush ? {ACC_SYMS{1'b0}} : acc_k_reg)
              | ({k, 3'b000} >> cnt_eff);
    total     = {1'b0, cnt_eff} + {1'b0, count};
    total_m4  = total - 4'd4;
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      acc_data_reg <= '0;
      acc_k_reg    <= '0;
      acc_cnt_reg  <= 3'd0;
      out_data     <= 32'h0;
      out_datak    <= 4'h0;
      out_valid    <= 1'b0;
    end else if (total >= 4'd4) begin
      out_data     <= comb_data[ACC_W-1 -: 32];
      out_datak    <= comb_k[ACC_SYMS-1 -: 4];
      out_valid    <= 1'b1;
      acc_data_reg <= {comb_data[ACC_W-33:0], 32'h0};
      acc_k_reg    <= {comb_k[ACC_SYMS-5:0], 4'h0};
      acc_cnt_reg  <= total_m4[2:0];
    end else begin
      out_valid    <= 1'b0;
      acc_data_reg <= comb_data;
      acc_k_reg    <= comb_k;
      acc_cnt_reg  <= total[2:0];
    end
  end

endmodule

// File: rtl/usb3_descramble.sv
// USB 3.0 RX descrambler: strips SKP, descrambles with COM-reseeded LFSR, repacks.
// Define USB3_RX_SKP_STATS_EN to build the saturating skp_total counter.
module usb3_descramble
  import usb3_descramble_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int          STRIP_SKP = 1
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_valid,
  output logic [2:0]  skp_removed,
  output logic [15:0] skp_total
);

  logic [7:0] lane_byte [4];
  sym_kind_t  lane_kind [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = in_data[31-8*gi -: 8];
      always_comb begin
        lane_kind[gi] = SYM_DATA;
        if (in_datak[3-gi]) begin
          if (lane_byte[gi] == K_COM)      lane_kind[gi] = SYM_COM;
          else if (lane_byte[gi] == K_SKP) lane_kind[gi] = SYM_SKP;
          else                             lane_kind[gi] = SYM_KOTHER;
        end
      end
    end
  endgenerate

  logic [15:0] lfsr_reg;
  logic [31:0] s1_data_reg;
  logic [3:0]  s1_k_reg;
  logic [2:0]  s1_cnt_reg;
  logic [2:0]  s1_skp_reg;
  logic        s1_bypass_reg;
  logic [2:0]  skp_removed_reg;

  logic [15:0] lfsr_next;
  logic [31:0] pack_d;
  logic [3:0]  pack_k;
  logic [2:0]  pack_n;
  logic [2:0]  skp_n;
  logic [31:0] aligned_d;
  logic [3:0]  aligned_k;
  lfsr_step_t  step;

  // Lanes are walked in time order so each COM reseeds for the lanes after it.
  always_comb begin
    lfsr_next = lfsr_reg;
    pack_d    = 32'h0;
    pack_k    = 4'h0;
    pack_n    = 3'd0;
    skp_n     = 3'd0;
    step      = '0;
    for (int i = 0; i < 4; i++) begin
      case (lane_kind[i])
        SYM_COM: begin
          pack_d    = {pack_d[23:0], lane_byte[i]};
          pack_k    = {pack_k[2:0], 1'b1};
          pack_n    = pack_n + 3'd1;
          lfsr_next = LFSR_SEED;
        end
        SYM_SKP: begin
          if (STRIP_SKP != 0) begin
            skp_n = skp_n + 3'd1;
          end else begin
            pack_d = {pack_d[23:0], lane_byte[i]};
            pack_k = {pack_k[2:0], 1'b1};
            pack_n = pack_n + 3'd1;
          end
        end
        SYM_KOTHER: begin
          step      = lfsr_step8(lfsr_next);
          pack_d    = {pack_d[23:0], lane_byte[i]};
          pack_k    = {pack_k[2:0], 1'b1};
          pack_n    = pack_n + 3'd1;
          lfsr_next = step.state;
        end
        default: begin
          step      = lfsr_step8(lfsr_next);
          pack_d    = {pack_d[23:0], lane_byte[i] ^ step.ks};
          pack_k    = {pack_k[2:0], 1'b0};
          pack_n    = pack_n + 3'd1;
          lfsr_next = step.state;
        end
      endcase
    end
    aligned_d = pack_d << {3'd4 - pack_n, 3'b000};
    aligned_k = pack_k << (3'd4 - pack_n);
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      lfsr_reg        <= LFSR_SEED;
      s1_data_reg     <= 32'h0;
      s1_k_reg        <= 4'h0;
      s1_cnt_reg      <= 3'd0;
      s1_skp_reg      <= 3'd0;
      s1_bypass_reg   <= 1'b0;
      skp_removed_reg <= 3'd0;
    end else begin
      skp_removed_reg <= s1_skp_reg;
      if (!enable) begin
        lfsr_reg      <= LFSR_SEED;
        s1_data_reg   <= in_valid ? in_data : 32'h0;
        s1_k_reg      <= in_valid ? in_datak : 4'h0;
        s1_cnt_reg    <= in_valid ? 3'd4 : 3'd0;
        s1_skp_reg    <= 3'd0;
        s1_bypass_reg <= 1'b1;
      end else if (in_valid) begin
        lfsr_reg      <= lfsr_next;
        s1_data_reg   <= aligned_d;
        s1_k_reg      <= aligned_k;
        s1_cnt_reg    <= pack_n;
        s1_skp_reg    <= skp_n;
        s1_bypass_reg <= 1'b0;
      end else begin
        s1_data_reg   <= 32'h0;
        s1_k_reg      <= 4'h0;
        s1_cnt_reg    <= 3'd0;
        s1_skp_reg    <= 3'd0;
        s1_bypass_reg <= 1'b0;
      end
    end
  end

  usb3_rx_pack u_pack (
    .local_clk (local_clk),
    .reset     (reset),
    .flush     (s1_bypass_reg),
    .symbols   (s1_data_reg),
    .k         (s1_k_reg),
    .count     (s1_cnt_reg),
    .out_data  (out_data),
    .out_datak (out_datak),
    .out_valid (out_valid)
  );

  assign skp_removed = skp_removed_reg;

`ifdef USB3_RX_SKP_STATS_EN
  logic [15:0] skp_total_reg;
  logic [16:0] skp_sum;
  assign skp_sum = {1'b0, skp_total_reg} + {14'h0, skp_removed_reg};
  always_ff @(posedge local_clk) begin
    if (reset) skp_total_reg <= 16'h0000;
    else       skp_total_reg <= skp_sum[16] ? 16'hFFFF : skp_sum[15:0];
  end
  assign skp_total = skp_total_reg;
`else
  assign skp_total = 16'h0000;
`endif

endmodule

// File: tb/tb_usb3_descramble.sv
// Directed table-driven bench for usb3_descramble plus reset, bypass and
// scrambled-loopback sequences; expected keystream comes from a local LFSR model.
module tb_usb3_descramble;

  logic        local_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_valid;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid;
  logic [2:0]  skp_removed;
  logic [15:0] skp_total;

  always #5 local_clk = ~local_clk;

  usb3_descramble dut (
    .local_clk   (local_clk),
    .reset       (reset),
    .enable      (enable),
    .in_data     (in_data),
    .in_datak    (in_datak),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_datak   (out_datak),
    .out_valid   (out_valid),
    .skp_removed (skp_removed),
    .skp_total   (skp_total)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic [2:0]  es;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ks_tab [64];
  vec_t        tab [11];
  logic [8:0]  exp_q [$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v, input logic en);
    in_data  = d;
    in_datak = k;
    in_valid = v;
    enable   = en;
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  // Pops four expected symbols whenever the DUT emits a word.
  task automatic lb_check();
    logic [35:0] expw;
    logic [8:0]  e;
    if (out_valid) begin
      if (exp_q.size() < 4) begin
        check("lb_underflow", exp_q.size(), 4);
      end else begin
        expw = '0;
        for (int l = 0; l < 4; l++) begin
          e = exp_q.pop_front();
          expw[35-l] = e[8];
          expw[31-8*l -: 8] = e[7:0];
        end
        check("lb_word", {out_datak, out_data}, expw);
      end
    end
  endtask

  initial begin
    logic [15:0] st;
    logic        fb;
    logic [31:0] w;
    logic [7:0]  b;
    int          pos;

    st = 16'h7DBD;
    for (int n = 0; n < 64; n++) begin
      for (int bi = 0; bi < 8; bi++) begin
        ks_tab[n][bi] = st[15];
        fb = st[15];
        st = st << 1;
        if (fb) st = st ^ 16'b0000_0000_0011_1001;
      end
    end

    tab[0]  = '{32'hBC000000, 4'h8, 1'b1, 1'b1, {8'hBC, ks_tab[0], ks_tab[1], ks_tab[2]}, 4'h8, 3'd0};
    tab[1]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, {ks_tab[3], ks_tab[4], ks_tab[5], ks_tab[6]}, 4'h0, 3'd0};
    tab[2]  = '{32'h3C3C3C3C, 4'hF, 1'b1, 1'b0, 32'h0, 4'h0, 3'd4};
    tab[3]  = '{32'h00000000, 4'h0, 1'b1, 1'b1, {ks_tab[7], ks_tab[8], ks_tab[9], ks_tab[10]}, 4'h0, 3'd0};
    tab[4]  = '{32'h3C3C1122, 4'hC, 1'b1, 1'b0, 32'h0, 4'h0, 3'd2};
    tab[5]  = '{32'h33445566, 4'h0, 1'b1, 1'b1,
                {8'h11 ^ ks_tab[11], 8'h22 ^ ks_tab[12], 8'h33 ^ ks_tab[13], 8'h44 ^ ks_tab[14]}, 4'h0, 3'd0};
    tab[6]  = '{32'hBC010203, 4'h8, 1'b1, 1'b1,
                {8'h55 ^ ks_tab[15], 8'h66 ^ ks_tab[16], 8'hBC, 8'h01 ^ ks_tab[0]}, 4'h2, 3'd0};
    tab[7]  = '{32'hAABBCCDD, 4'h0, 1'b1, 1'b1,
                {8'h02 ^ ks_tab[1], 8'h03 ^ ks_tab[2], 8'hAA ^ ks_tab[3], 8'hBB ^ ks_tab[4]}, 4'h0, 3'd0};
    tab[8]  = '{32'hBC10BC20, 4'hA, 1'b1, 1'b1,
                {8'hCC ^ ks_tab[5], 8'hDD ^ ks_tab[6], 8'hBC, 8'h10 ^ ks_tab[0]}, 4'h2, 3'd0};
    tab[9]  = '{32'h00000000, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 3'd0};
    tab[10] = '{32'hF7000000, 4'h8, 1'b1, 1'b1,
                {8'hBC, 8'h20 ^ ks_tab[0], 8'hF7, ks_tab[2]}, 4'hA, 3'd0};

    // Reset state
    reset = 1'b1;
    drive(32'h0, 4'h0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_data", out_data, 32'h0);
    check("rst_datak", out_datak, 4'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_skp", skp_removed, 3'd0);
    check("rst_total", skp_total, 16'h0);
    reset = 1'b0;

    // Streaming table: outputs after a tick reflect the vector one iteration back
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) drive(tab[i].d, tab[i].k, tab[i].v, 1'b1);
      else        drive(32'h0, 4'h0, 1'b0, 1'b1);
      tick();
      if (i > 0) begin
        check($sformatf("vec%0d_valid", i-1), out_valid, tab[i-1].ev);
        check($sformatf("vec%0d_skp", i-1), skp_removed, tab[i-1].es);
        if (tab[i-1].ev) begin
          check($sformatf("vec%0d_data", i-1), out_data, tab[i-1].ed);
          check($sformatf("vec%0d_datak", i-1), out_datak, tab[i-1].ek);
        end
      end
    end

    // Bypass: two symbols are still held; enable=0 must drop them
    drive(32'hDEADBEEF, 4'h0, 1'b1, 1'b0);
    tick();
    drive(32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    check("byp_data", out_data, 32'hDEADBEEF);
    check("byp_datak", out_datak, 4'h0);
    check("byp_valid", out_valid, 1'b1);
    check("byp_skp", skp_removed, 3'd0);
    tick();
    check("byp_idle_valid", out_valid, 1'b0);

    // Reset with three symbols held, then a clean COM word
    drive(32'hBC000000, 4'h8, 1'b1, 1'b1);
    tick();
    drive(32'h3C010203, 4'h8, 1'b1, 1'b1);
    tick();
    check("pre_rst_data", out_data, {8'hBC, ks_tab[0], ks_tab[1], ks_tab[2]});
    drive(32'h0, 4'h0, 1'b0, 1'b1);
    tick();
    check("held3_skp", skp_removed, 3'd1);
    check("held3_valid", out_valid, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_data", out_data, 32'h0);
    check("midrst_valid", out_valid, 1'b0);
    reset = 1'b0;
    drive(32'hBCA1A2A3, 4'h8, 1'b1, 1'b1);
    tick();
    drive(32'h0, 4'h0, 1'b0, 1'b1);
    tick();
    check("postrst_data", out_data,
          {8'hBC, 8'hA1 ^ ks_tab[0], 8'hA2 ^ ks_tab[1], 8'hA3 ^ ks_tab[2]});
    check("postrst_datak", out_datak, 4'h8);
    check("postrst_valid", out_valid, 1'b1);

    // Loopback: scrambled stream with SKP words must come back as raw data
    pos = 0;
    w = {8'hBC, 24'h0};
    exp_q.push_back({1'b1, 8'hBC});
    for (int l = 1; l < 4; l++) begin
      b = 8'($urandom);
      w[31-8*l -: 8] = b ^ ks_tab[pos];
      pos++;
      exp_q.push_back({1'b0, b});
    end
    drive(w, 4'h8, 1'b1, 1'b1);
    tick();
    lb_check();
    for (int wi = 0; wi < 12; wi++) begin
      if (wi % 4 == 3) begin
        drive(32'h3C3C3C3C, 4'hF, 1'b1, 1'b1);
        tick();
        lb_check();
      end
      for (int l = 0; l < 4; l++) begin
        b = 8'($urandom);
        w[31-8*l -: 8] = b ^ ks_tab[pos];
        pos++;
        exp_q.push_back({1'b0, b});
      end
      drive(w, 4'h0, 1'b1, 1'b1);
      tick();
      lb_check();
    end
    drive(32'h0, 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      lb_check();
    end
    check("lb_leftover", exp_q.size(), 0);

`ifdef USB3_RX_SKP_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(32'h3C3C3C3C, 4'hF, 1'b1, 1'b1);
      tick();
    end
    drive(32'h0, 4'h0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    check("skp_total80", skp_total, 16'd80);
`else
    check("skp_total_tied", skp_total, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
